// File: rtl/spi_tx_feeder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_tx_feeder_if                                                   |
// | Write-side and transmitter-side signals of the SPI byte feeder.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface spi_tx_feeder_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_dc;
  logic [7:0] cfg_prescalor;
  logic       clr_err;
  logic       spi_valid;
  logic [9:0] control;
  logic [7:0] data_in;
  logic       full;
  logic       empty;
  logic       busy;
  logic       done;
  logic       ovf;
  logic       tmo;

  modport master (
    output wr_en, wr_data, wr_dc, cfg_prescalor, clr_err, spi_valid,
    input  control, data_in, full, empty, busy, done, ovf, tmo
  );

  modport slave (
    input  wr_en, wr_data, wr_dc, cfg_prescalor, clr_err, spi_valid,
    output control, data_in, full, empty, busy, done, ovf, tmo
  );
endinterface
`default_nettype wire

// File: rtl/spi_tx_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_tx_feeder                                                      |
// | FIFO-buffered byte sequencer feeding the SPI transmitter control.  |
// | Optional watchdog: define SPI_FEED_TIMEOUT_EN.                     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module spi_tx_feeder #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input logic            clk,
  input logic            reset,
  spi_tx_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t        r_state;
  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;
  logic          r_enable;
  logic          r_dc;
  logic          r_busy;
  logic          r_done;
  logic [7:0]    r_presc;
  logic [7:0]    r_data;
  logic [7:0]    r_gap;
  logic          w_push;
  logic          w_pop;

`ifdef SPI_FEED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wdog;
  logic          r_tmo;
`endif

  // full is the registered value, so a same-cycle pop never frees room for a push
  assign w_push = bus.wr_en && !r_full;
  assign w_pop  = (r_state == S_LOAD);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + CW'(1);
    else if (!w_push && w_pop)
      w_count_next = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= {bus.wr_dc, bus.wr_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      r_empty <= (w_count_next == '0);
      if (bus.clr_err)
        r_ovf <= 1'b0;
      if (bus.wr_en && r_full)
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_enable <= 1'b0;
      r_dc     <= 1'b0;
      r_data   <= '0;
      r_presc  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_gap    <= '0;
`ifdef SPI_FEED_TIMEOUT_EN
      r_wdog   <= '0;
      r_tmo    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef SPI_FEED_TIMEOUT_EN
      if (bus.clr_err)
        r_tmo <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_enable <= 1'b0;
          if (!r_empty) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          {r_dc, r_data} <= r_mem[r_rptr];
          r_presc        <= bus.cfg_prescalor;
          r_state        <= S_START;
        end
        S_START: begin
          r_enable <= 1'b1;
          r_state  <= S_WAIT;
`ifdef SPI_FEED_TIMEOUT_EN
          r_wdog   <= '0;
`endif
        end
        S_WAIT: begin
          if (bus.spi_valid) begin
            r_enable <= 1'b0;
            r_done   <= 1'b1;
            r_gap    <= '0;
            r_state  <= S_GAP;
          end
`ifdef SPI_FEED_TIMEOUT_EN
          else if (r_wdog == TW'(TIMEOUT - 1)) begin
            r_enable <= 1'b0;
            r_tmo    <= 1'b1;
            r_gap    <= '0;
            r_state  <= S_GAP;
          end else begin
            r_wdog <= r_wdog + TW'(1);
          end
`endif
        end
        S_GAP: begin
          r_enable <= 1'b0;
          if (r_gap == 8'(GAP_CYCLES - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap + 8'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_enable <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.control = {r_presc, r_dc, r_enable};
  assign bus.data_in = r_data;
  assign bus.full    = r_full;
  assign bus.empty   = r_empty;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.ovf     = r_ovf;
`ifdef SPI_FEED_TIMEOUT_EN
  assign bus.tmo     = r_tmo;
`else
  assign bus.tmo     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/spi_tx_feeder.md
# spi_tx_feeder

Byte-stream sequencer that sits directly upstream of the SPI transmit top. It buffers command/data bytes in a small FIFO and drives that block's 10-bit control word (enable, data/command select, SCL prescaler) and 8-bit data input. For each byte it generates one enable rising edge, then waits for the transmitter's completion strobe before issuing the next byte. Display drivers write whole init/draw sequences into it and poll `busy`/`empty`.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≥2.
- `GAP_CYCLES`, 2: enable-low cycles after each completion before the next byte. Range 1..255.
- `TIMEOUT`, 4096: watchdog limit in clk cycles. Used only with `SPI_FEED_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: **asynchronous, active-low** reset. Asserted at 0.
- `wr_en` in 1: push `{wr_dc, wr_data}` into the FIFO.
- `wr_data` in 8: byte to send.
- `wr_dc` in 1: 0 = command byte, 1 = data byte.
- `cfg_prescalor` in 8: SCL prescaler. Sampled per byte in LOAD.
- `clr_err` in 1: clears the `ovf` and `tmo` sticky flags.
- `spi_valid` in 1: completion strobe from the SPI transmitter.
- `control` out 10: `{prescalor[7:0], dc, enable}` to the transmitter.
- `data_in` out 8: byte to the transmitter.
- `full`, `empty` out 1: FIFO status. Registered.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a byte completes.
- `ovf` out 1: sticky. Set when a write is attempted while full.
- `tmo` out 1: sticky. Watchdog fired. Held 0 without the macro.

## Operation
Reset values:
- `control` = 0, `data_in` = 0.
- `full` = 0, `empty` = 1.
- `busy`, `done`, `ovf`, `tmo` = 0.
- State = IDLE, FIFO pointers and count = 0.

FIFO:
- `DEPTH`×9 bits; count width is clog2(DEPTH)+1.
- A write is accepted when `wr_en` && !`full`, where `full` is evaluated before any same-cycle pop.
- A write while full is dropped and sets `ovf`.
- Simultaneous push and pop leaves the count unchanged.
- Pointers wrap modulo `DEPTH`.

State machine:
- **IDLE**: `enable` = 0. If !`empty`, go to LOAD.
- **LOAD**: pop the head entry. Register `data_in` ← byte, `dc` ← flag, `prescalor` ← `cfg_prescalor`. `enable` stays 0. Go to START.
- **START**: `enable` ← 1. Go to WAIT.
- **WAIT**: `enable` held 1.
  - On `spi_valid` == 1: `enable` ← 0, pulse `done`, go to GAP.
  - A `spi_valid` already high on entry to WAIT counts.
- **GAP**: `enable` = 0 for `GAP_CYCLES` cycles, then go to IDLE.

Output hold rules:
- `dc`, `data_in` and `prescalor` are held from LOAD until the next LOAD. `dc` must not change while the transmitter's chip select is low.
- `spi_valid` outside WAIT is ignored.

Other boundaries:
- `clr_err` together with a new error event in the same cycle: the set wins.
- Reset asserted mid-byte returns everything to reset values immediately. Queued bytes are discarded and `enable` drops asynchronously.

## Timing
- Write at edge n into an empty FIFO: `empty` falls after n.
- State path: IDLE at n+1, LOAD at n+2 with `data_in`/`dc` valid after it, START at n+3 with `enable` rising after it.
- `enable` falls on the edge after `spi_valid` is sampled high. `done` is high in that same cycle.
- Minimum spacing between successive `enable` rising edges is `GAP_CYCLES` + 4 cycles plus the transmitter time.
- No combinational path from inputs to outputs.

## Configuration
Macro `SPI_FEED_TIMEOUT_EN`.

- **Defined**: a counter runs in WAIT. If it reaches `TIMEOUT` cycles without `spi_valid`:
  - drop `enable`;
  - set `tmo`;
  - do not pulse `done`;
  - go to GAP.
  The byte is lost. The counter clears on every entry to WAIT.
- **Undefined**: no counter. WAIT waits indefinitely and `tmo` is tied 0.

## Test plan
- **Reset state**: reset low, then release → all outputs at reset values, `empty` = 1, `control` = 10'h000.
- **Single byte**: push cmd 8'hAE with `cfg_prescalor` = 8'd4. Then:
  - `control` = {8'd4, 0, 1} three cycles after `empty` falls;
  - model `spi_valid` 20 cycles later → `done` pulse, `enable` = 0 for 2 cycles;
  - `busy` falls.
- **Back-to-back**: push 8'h21 (cmd), 8'h55 (data), 8'hAA (data) in consecutive cycles → three `enable` rising edges in order, `dc` sequence 0, 1, 1, three `done` pulses, `empty` = 1 at the end.
- **Overflow**: with `spi_valid` held 0, write 17 bytes at DEPTH = 16. The first byte pops, so 16 remain queued → no `ovf`. Write one more → `ovf` = 1. Pulse `clr_err` → `ovf` = 0.
- **Reset mid-byte**: assert reset while in WAIT with 3 bytes queued → `enable` = 0 asynchronously, `empty` = 1 after release, no `done`.
- **Timeout** (macro defined, TIMEOUT = 64): push one byte, never assert `spi_valid` → `enable` falls 64 cycles after WAIT entry, `tmo` = 1, no `done`, next byte proceeds normally.
